// File: rtl/twowire_apb_arbiter_pkg.sv
// Shared types for the two-wire APB arbiter: the transfer state encoding
// and the index-width helper.
package twowire_apb_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/twowire_rr_priority.sv
// Combinational priority pick: first unmasked request at or after ptr,
// wrapping modulo N.
module twowire_rr_priority import twowire_apb_arbiter_pkg::*; #(
  parameter int N     = 2,
  parameter int W_IDX = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [W_IDX-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic             vld,
  output logic [W_IDX-1:0] win
);

  // Walk from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    vld = 1'b0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N] && !mask[(int'(ptr) + k) % N]) begin
        vld = 1'b1;
        win = W_IDX'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/twowire_apb_arbiter.sv
// Shares one APB3 target between N_PORTS requesters; holds a registered
// grant for a whole transfer and sequences setup/access downstream.
module twowire_apb_arbiter import twowire_apb_arbiter_pkg::*; #(
  parameter int N_PORTS     = 2,
  parameter int W_ADDR      = 8,
  parameter int W_DATA      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                      dck,
  input  logic                      drst_n,
  input  logic [N_PORTS-1:0]        us_psel,
  input  logic [N_PORTS-1:0]        us_penable,
  input  logic [N_PORTS-1:0]        us_pwrite,
  input  logic [N_PORTS*W_ADDR-1:0] us_paddr,
  input  logic [N_PORTS*W_DATA-1:0] us_pwdata,
  output logic [N_PORTS-1:0]        us_pready,
  output logic [N_PORTS-1:0]        us_pslverr,
  output logic [W_DATA-1:0]         us_prdata,
  output logic                      ds_psel,
  output logic                      ds_penable,
  output logic                      ds_pwrite,
  output logic [W_ADDR-1:0]         ds_paddr,
  output logic [W_DATA-1:0]         ds_pwdata,
  input  logic                      ds_pready,
  input  logic                      ds_pslverr,
  input  logic [W_DATA-1:0]         ds_prdata,
  output logic                      busy
);

  localparam int W_IDX = idx_w(N_PORTS);

  if (N_PORTS < 2 || N_PORTS > 8) begin : g_bad_n_ports
    $error("twowire_apb_arbiter: N_PORTS must be in 2..8");
  end

  state_t             state, state_nxt;
  logic [W_IDX-1:0]   grant, grant_nxt, rr_ptr, ptr_nxt, start, win;
  logic               win_vld, take, done;
  logic [N_PORTS-1:0] gsel, mask;

  // Arbitration is on psel alone; penable carries no extra information here.
  logic unused_penable;
  assign unused_penable = ^us_penable;

  assign gsel  = N_PORTS'(1) << grant;
  // The finishing port still holds psel in its completion cycle.
  assign mask  = (state == S_ACCESS) ? gsel : '0;
  assign start = (ROUND_ROBIN != 0) ? rr_ptr : '0;

  twowire_rr_priority #(.N(N_PORTS), .W_IDX(W_IDX)) u_pri (
    .req  (us_psel),
    .ptr  (start),
    .mask (mask),
    .vld  (win_vld),
    .win  (win)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = rr_ptr;
    take      = 1'b0;
    case (state)
      S_IDLE:   take = win_vld;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (ds_pready) begin
                  take      = win_vld;
                  state_nxt = S_IDLE;
                end
      default:  state_nxt = S_IDLE;
    endcase
    if (take) begin
      state_nxt = S_SETUP;
      grant_nxt = win;
      if (ROUND_ROBIN != 0)
        ptr_nxt = (win == W_IDX'(N_PORTS - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= ptr_nxt;
    end
  end

  assign busy       = (state != S_IDLE);
  assign ds_psel    = (state == S_SETUP) || (state == S_ACCESS);
  assign ds_penable = (state == S_ACCESS);
  assign ds_pwrite  = ds_psel & us_pwrite[grant];
  assign ds_paddr   = ds_psel ? us_paddr[grant*W_ADDR +: W_ADDR]  : '0;
  assign ds_pwdata  = ds_psel ? us_pwdata[grant*W_DATA +: W_DATA] : '0;

  assign done       = (state == S_ACCESS) && ds_pready;
  assign us_pready  = done ? gsel : '0;
  assign us_pslverr = (done && ds_pslverr) ? gsel : '0;
  assign us_prdata  = ds_prdata;

endmodule

// File: tb/tb_twowire_apb_arbiter.sv
// Bench: round-robin and fixed-priority arbiters on shared stimulus, both
// checked every cycle against a transfer-level reference model.
module tb_twowire_apb_arbiter;
  localparam int N = 2, WA = 8, WD = 32;

  logic dck = 1'b0, drst_n = 1'b0;
  always #5 dck = ~dck;

  logic [N-1:0]    psel = '0, penable = '0, pwrite = '0;
  logic [N*WA-1:0] paddr = '0;
  logic [N*WD-1:0] pwdata = '0;
  logic            ds_pready = 1'b0, ds_pslverr = 1'b0;
  logic [WD-1:0]   ds_prdata = '0;

  logic [1:0]             o_psel, o_pen, o_pwrite, o_busy;
  logic [1:0][WA-1:0]     o_paddr;
  logic [1:0][WD-1:0]     o_pwdata, o_prdata;
  logic [1:0][N-1:0]      o_rdy, o_err;

  twowire_apb_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ROUND_ROBIN(1)) u_rr (
    .dck(dck), .drst_n(drst_n), .us_psel(psel), .us_penable(penable), .us_pwrite(pwrite),
    .us_paddr(paddr), .us_pwdata(pwdata), .us_pready(o_rdy[0]), .us_pslverr(o_err[0]),
    .us_prdata(o_prdata[0]), .ds_psel(o_psel[0]), .ds_penable(o_pen[0]), .ds_pwrite(o_pwrite[0]),
    .ds_paddr(o_paddr[0]), .ds_pwdata(o_pwdata[0]), .ds_pready(ds_pready),
    .ds_pslverr(ds_pslverr), .ds_prdata(ds_prdata), .busy(o_busy[0]));

  twowire_apb_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ROUND_ROBIN(0)) u_fp (
    .dck(dck), .drst_n(drst_n), .us_psel(psel), .us_penable(penable), .us_pwrite(pwrite),
    .us_paddr(paddr), .us_pwdata(pwdata), .us_pready(o_rdy[1]), .us_pslverr(o_err[1]),
    .us_prdata(o_prdata[1]), .ds_psel(o_psel[1]), .ds_penable(o_pen[1]), .ds_pwrite(o_pwrite[1]),
    .ds_paddr(o_paddr[1]), .ds_pwdata(o_pwdata[1]), .ds_pready(ds_pready),
    .ds_pslverr(ds_pslverr), .ds_prdata(ds_prdata), .busy(o_busy[1]));

  int checks = 0, failures = 0;
  // Reference model: owner port (-1 = none), phase within transfer, next search start.
  int m_own[2], m_ph[2], m_ptr[2];
  int cyc = 0;
  logic [N-1:0] last_rdy = '0;
  bit tag_addr = 1'b0;
  // Observations of the round-robin instance from the latest cycle.
  logic          ob_psel, ob_pen, ob_busy;
  logic [N-1:0]  ob_rdy, ob_err;
  logic [WA-1:0] ob_paddr;
  logic [WD-1:0] ob_pwdata, ob_prdata;
  int setup_addr[$], setup_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from, input int excl);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (from + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_ph[k] = 0; m_ptr[k] = 0;
    end
  endtask

  // One clock cycle: entered just after a rising edge with inputs set.
  task automatic step();
    logic          e_sel, e_en, e_wr;
    logic [N-1:0]  er, ee;
    logic [WA-1:0] ea;
    logic [WD-1:0] ed;
    int w, from;
    @(negedge dck);
    for (int k = 0; k < 2; k++) begin
      e_sel = (m_own[k] >= 0);
      e_en  = e_sel && (m_ph[k] == 1);
      er = '0; ee = '0; ea = '0; ed = '0; e_wr = 1'b0;
      if (e_sel) begin
        ea = paddr[m_own[k]*WA +: WA];
        ed = pwdata[m_own[k]*WD +: WD];
        e_wr = pwrite[m_own[k]];
      end
      if (e_en && ds_pready) begin
        er[m_own[k]] = 1'b1;
        ee[m_own[k]] = ds_pslverr;
      end
      chk($sformatf("psel%0d", k),   o_psel[k],   e_sel);
      chk($sformatf("pen%0d", k),    o_pen[k],    e_en);
      chk($sformatf("busy%0d", k),   o_busy[k],   e_sel);
      chk($sformatf("pwrite%0d", k), o_pwrite[k], e_wr);
      chk($sformatf("paddr%0d", k),  o_paddr[k],  ea);
      chk($sformatf("pwdata%0d", k), o_pwdata[k], ed);
      chk($sformatf("rdy%0d", k),    o_rdy[k],    er);
      chk($sformatf("err%0d", k),    o_err[k],    ee);
      chk($sformatf("prdata%0d", k), o_prdata[k], ds_prdata);
      if (k == 0) last_rdy = er;
      from = (k == 0) ? m_ptr[k] : 0;
      w = -1;
      if (m_own[k] < 0) w = pick(psel, from, -1);
      else if (m_ph[k] == 0) m_ph[k] = 1;
      else if (ds_pready) begin
        w = pick(psel, from, m_own[k]);
        if (w < 0) m_own[k] = -1;
      end
      if (w >= 0) begin
        m_own[k] = w; m_ph[k] = 0;
        if (k == 0) m_ptr[k] = (w + 1) % N;
      end
    end
    ob_psel = o_psel[0]; ob_pen = o_pen[0]; ob_busy = o_busy[0];
    ob_rdy = o_rdy[0]; ob_err = o_err[0]; ob_paddr = o_paddr[0];
    ob_pwdata = o_pwdata[0]; ob_prdata = o_prdata[0];
    if (o_psel[0] && !o_pen[0]) begin
      setup_addr.push_back(int'(o_paddr[0]));
      setup_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge dck); #1;
  endtask

  task automatic new_req(input int i);
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = 1'($urandom);
    paddr[i*WA +: WA] = tag_addr ? WA'(8'hA0 + i) : WA'($urandom);
    pwdata[i*WD +: WD] = $urandom;
  endtask

  // Upstream masters: finish on the model's pready, then maybe re-request.
  task automatic drive_masters(input int p_new);
    for (int i = 0; i < N; i++) begin
      if (psel[i] && last_rdy[i]) begin
        if ($urandom_range(99) < p_new) new_req(i);
        else begin psel[i] = 1'b0; penable[i] = 1'b0; end
      end else if (psel[i]) penable[i] = 1'b1;
      else if ($urandom_range(99) < p_new) new_req(i);
    end
  endtask

  // Entered just after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2 drst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_psel%0d", k), o_psel[k], 1'b0);
      chk($sformatf("rst_pen%0d", k),  o_pen[k],  1'b0);
      chk($sformatf("rst_busy%0d", k), o_busy[k], 1'b0);
      chk($sformatf("rst_rdy%0d", k),  o_rdy[k],  '0);
      chk($sformatf("rst_err%0d", k),  o_err[k],  '0);
    end
    model_reset();
    psel = '0; penable = '0; last_rdy = '0;
    ds_pready = 1'b0; ds_pslverr = 1'b0;
    @(posedge dck); #2 drst_n = 1'b1;
    @(posedge dck); #1;
  endtask

  initial begin
    model_reset();
    @(posedge dck); #1;
    do_reset();

    // Single write, no contention.
    psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[7:0] = 8'h10; pwdata[31:0] = 32'hDEADBEEF;
    ds_pready = 1'b1;
    step(); drive_masters(0);
    chk("t1_c0_psel", ob_psel, 1'b0);
    step(); drive_masters(0);
    chk("t1_c1_psel", ob_psel, 1'b1);
    chk("t1_c1_pen", ob_pen, 1'b0);
    chk("t1_c1_addr", ob_paddr, 8'h10);
    chk("t1_c1_wdata", ob_pwdata, 32'hDEADBEEF);
    step(); drive_masters(0);
    chk("t1_c2_pen", ob_pen, 1'b1);
    chk("t1_c2_rdy", ob_rdy, 2'b01);
    step(); drive_masters(0);
    chk("t1_c3_busy", ob_busy, 1'b0);

    // Simultaneous requests from reset.
    do_reset();
    setup_addr.delete(); setup_cyc.delete();
    psel = 2'b11; pwrite = 2'b10; paddr[7:0] = 8'h04; paddr[15:8] = 8'h08;
    ds_pready = 1'b1;
    repeat (8) begin step(); drive_masters(0); end
    chk("t2_count", setup_addr.size(), 2);
    if (setup_addr.size() >= 2) begin
      chk("t2_first", setup_addr[0], 8'h04);
      chk("t2_second", setup_addr[1], 8'h08);
      chk("t2_gap", setup_cyc[1] - setup_cyc[0], 2);
    end
    // rr_ptr wrapped to 0: a fresh pair goes to port 0 first.
    tag_addr = 1'b1; setup_addr.delete(); setup_cyc.delete();
    new_req(0); new_req(1);
    repeat (3) begin step(); drive_masters(0); end
    chk("t2_ptr0", setup_addr.size() > 0 ? setup_addr[0] : -1, 8'hA0);
    repeat (5) begin step(); drive_masters(0); end

    // Wait states and slave error on port 1.
    do_reset();
    new_req(1); pwrite[1] = 1'b0;
    repeat (5) begin
      step(); drive_masters(0);
      chk("t3_wait_rdy", ob_rdy, 2'b00);
    end
    ds_pready = 1'b1; ds_pslverr = 1'b1; ds_prdata = 32'h12345678;
    step(); drive_masters(0);
    chk("t3_rdy", ob_rdy, 2'b10);
    chk("t3_err", ob_err, 2'b10);
    chk("t3_prdata", ob_prdata, 32'h12345678);
    ds_pslverr = 1'b0;
    step(); drive_masters(0);

    // Back-to-back fairness with both ports always requesting.
    do_reset();
    setup_addr.delete(); setup_cyc.delete();
    new_req(0); new_req(1); ds_pready = 1'b1;
    for (int n = 0; n < 40 && setup_addr.size() < 6; n++) begin
      step(); drive_masters(100);
    end
    chk("t4_count", setup_addr.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < setup_addr.size(); i++)
      chk($sformatf("t4_grant%0d", i), setup_addr[i], 8'hA0 + (i % 2));

    // Reset mid-access, then arbitration restarts from port 0.
    do_reset();
    new_req(0); ds_pready = 1'b1;
    repeat (3) begin step(); drive_masters(0); end
    repeat (2) begin step(); drive_masters(0); end
    new_req(0); ds_pready = 1'b0;
    repeat (3) begin step(); drive_masters(0); end
    chk("t5_in_access", ob_pen, 1'b1);
    do_reset();
    setup_addr.delete(); setup_cyc.delete();
    new_req(0); new_req(1); ds_pready = 1'b1;
    repeat (3) begin step(); drive_masters(0); end
    chk("t5_restart", setup_addr.size() > 0 ? setup_addr[0] : -1, 8'hA0);
    repeat (6) begin step(); drive_masters(0); end

    // Self-mask: lone port completes with psel still high.
    do_reset();
    setup_addr.delete(); setup_cyc.delete();
    new_req(0); ds_pready = 1'b1;
    repeat (3) begin step(); drive_masters(0); end
    step(); drive_masters(0);
    chk("t6_idle", ob_busy, 1'b0);
    step(); drive_masters(0);
    chk("t6_once", setup_addr.size(), 1);

    // Random traffic against the model.
    do_reset();
    tag_addr = 1'b0;
    repeat (3000) begin
      ds_pready  = ($urandom_range(99) < 60);
      ds_pslverr = ($urandom_range(3) == 0);
      ds_prdata  = $urandom;
      step();
      drive_masters(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
